// File: rtl/qpsk_tx_ctrl.sv
// QPSK transmit framer: one-byte holding register feeding preamble / MSB-first dibit data / tail symbols.
// Symbols last SYM_DIV cycles; the hold is refilled while the shift register drains, so bytes stream gap-free.
module qpsk_tx_ctrl #(
   parameter int SYM_DIV   = 800,
   parameter int PRE_SYMS  = 8,
   parameter int TAIL_SYMS = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   output logic       in_ready,
   output logic       sym_i,
   output logic       sym_q,
   output logic       sym_strobe,
   output logic       tx_en,
   output logic       busy
);
   localparam int DW   = (SYM_DIV > 1) ? $clog2(SYM_DIV) : 1;
   localparam int SMAX = (PRE_SYMS > TAIL_SYMS) ? PRE_SYMS : TAIL_SYMS;
   localparam int SW   = (SMAX > 1) ? $clog2(SMAX) : 1;

   typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, TAIL} state_t;

   state_t        state, state_nxt;
   logic [DW-1:0] div_cnt;
   logic [SW-1:0] sym_cnt;
   logic [1:0]    dibit_idx;
   logic [7:0]    shift_reg;
   logic [7:0]    hold_dat;
   logic          hold_full;
   logic          sym_end;
   logic          load_shift;

   assign busy       = (state != IDLE);
   assign tx_en      = busy;
   assign in_ready   = ~hold_full;
   assign sym_strobe = busy && (div_cnt == '0);
   assign sym_end    = busy && (div_cnt == DW'(SYM_DIV - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      load_shift = 1'b0;
      case (state)
         IDLE: begin
            if (hold_full) state_nxt = PREAMBLE;
         end
         PREAMBLE: begin
            if (sym_end && (sym_cnt == SW'(PRE_SYMS - 1))) begin
               state_nxt  = DATA;
               load_shift = 1'b1;
            end
         end
         DATA: begin
            // Last dibit of the byte: chain straight into the next byte if one is waiting
            if (sym_end && (dibit_idx == 2'd3)) begin
               if (hold_full) load_shift = 1'b1;
               else           state_nxt  = TAIL;
            end
         end
         TAIL: begin
            if (sym_end && (sym_cnt == SW'(TAIL_SYMS - 1))) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt   <= '0;
         sym_cnt   <= '0;
         dibit_idx <= 2'd0;
         shift_reg <= 8'd0;
         hold_dat  <= 8'd0;
         hold_full <= 1'b0;
      end else begin
         if (!busy || sym_end) div_cnt <= '0;
         else                  div_cnt <= div_cnt + 1'b1;

         if (state_nxt != state) sym_cnt <= '0;
         else if (sym_end)       sym_cnt <= sym_cnt + 1'b1;

         if (load_shift) begin
            dibit_idx <= 2'd0;
            shift_reg <= hold_dat;
         end else if ((state == DATA) && sym_end) begin
            dibit_idx <= dibit_idx + 2'd1;
            shift_reg <= {shift_reg[5:0], 2'b00};
         end

         // Loading only happens while the hold is full, so it never collides with an accept
         if (load_shift) begin
            hold_full <= 1'b0;
         end else if (in_valid && !hold_full) begin
            hold_full <= 1'b1;
            hold_dat  <= in_data;
         end
      end
   end

   always_comb begin
      sym_i = 1'b0;
      sym_q = 1'b0;
      case (state)
         PREAMBLE: begin
            sym_i = 1'b1;
            sym_q = 1'b1;
         end
         DATA: begin
            sym_i = shift_reg[7];
            sym_q = shift_reg[6];
         end
         default: begin
            sym_i = 1'b0;
            sym_q = 1'b0;
         end
      endcase
   end
endmodule

// File: tb/tb_qpsk_tx_ctrl.sv
// Bench for qpsk_tx_ctrl: queue-based frame model checked every cycle, plus literal symbol sequences.
module tb_qpsk_tx_ctrl;
   localparam int SYM_DIV   = 4;
   localparam int PRE_SYMS  = 2;
   localparam int TAIL_SYMS = 1;

   logic       clk;
   logic       rst_n;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic       sym_i;
   logic       sym_q;
   logic       sym_strobe;
   logic       tx_en;
   logic       busy;

   qpsk_tx_ctrl #(.SYM_DIV(SYM_DIV), .PRE_SYMS(PRE_SYMS), .TAIL_SYMS(TAIL_SYMS)) dut (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .sym_i(sym_i), .sym_q(sym_q), .sym_strobe(sym_strobe), .tx_en(tx_en), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s at %0t: got=%0h expected=%0h", nm, $time, got, exp);
   endtask

   // Model: a frame is a queue of symbols; at every symbol boundary the next symbol is popped,
   // and when the queue runs dry the frame rules decide whether to append a byte, a tail, or stop.
   logic [1:0] mq[$];
   bit         m_idle = 1'b1;
   bit         m_full = 1'b0;
   bit         m_tail = 1'b0;
   bit         m_acc;
   logic [7:0] m_dat  = 8'd0;
   int         m_cnt  = 0;
   logic [1:0] m_cur  = 2'b00;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mq.delete();
         m_idle = 1'b1; m_full = 1'b0; m_tail = 1'b0; m_cnt = 0; m_cur = 2'b00;
      end else begin
         m_acc = in_valid && !m_full;
         if (m_idle) begin
            if (m_full) begin
               m_idle = 1'b0; m_tail = 1'b0; m_cnt = 0;
               for (int k = 0; k < PRE_SYMS; k++) mq.push_back(2'b11);
               m_cur = mq.pop_front();
            end
         end else if (m_cnt == SYM_DIV - 1) begin
            m_cnt = 0;
            if (mq.size() == 0) begin
               if (m_tail) begin
                  m_idle = 1'b1;
               end else if (m_full) begin
                  for (int k = 3; k >= 0; k--) mq.push_back(m_dat[2*k +: 2]);
                  m_full = 1'b0;
               end else begin
                  for (int k = 0; k < TAIL_SYMS; k++) mq.push_back(2'b00);
                  m_tail = 1'b1;
               end
            end
            if (m_idle) m_cur = 2'b00;
            else        m_cur = mq.pop_front();
         end else begin
            m_cnt++;
         end
         if (m_acc) begin
            m_full = 1'b1;
            m_dat  = in_data;
         end
      end
   end

   logic [1:0] sym_log[$];
   int         stb_cyc[$];
   int         cyc  = 0;
   int         bcnt = 0;
   logic [5:0] exp_out;

   always @(negedge clk) begin
      cyc++;
      if (rst_n) begin
         exp_out = {!m_full, m_cur, !m_idle && (m_cnt == 0), !m_idle, !m_idle};
         check("cycle_outputs{rdy,i,q,stb,txen,busy}",
               {26'd0, in_ready, sym_i, sym_q, sym_strobe, tx_en, busy}, {26'd0, exp_out});
         if (sym_strobe) begin
            sym_log.push_back({sym_i, sym_q});
            stb_cyc.push_back(cyc);
         end
         if (busy) bcnt++;
      end
   end

   logic [1:0] exp_q[$];

   task automatic chk_log(input string nm);
      check({nm, "_count"}, sym_log.size(), exp_q.size());
      for (int k = 0; k < exp_q.size(); k++)
         check(nm, (k < sym_log.size()) ? {30'd0, sym_log[k]} : 32'hDEAD, {30'd0, exp_q[k]});
   endtask

   task automatic clear_log();
      @(posedge clk); #1;
      sym_log.delete();
      stb_cyc.delete();
      bcnt = 0;
   endtask

   task automatic send(input logic [7:0] b);
      int n = 0;
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = b;
      while (!in_ready && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (n >= 400) check("send_timeout", 0, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_log(input int sz);
      int n = 0;
      while (sym_log.size() < sz && n < 1000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 1000) check("wait_log_timeout", 0, 1);
   endtask

   task automatic wait_idle();
      int n = 0;
      while (!busy && n < 50) begin @(negedge clk); n++; end
      n = 0;
      while (busy && n < 2000) begin @(negedge clk); n++; end
      if (n >= 2000) check("wait_idle_timeout", 0, 1);
   endtask

   initial begin
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'd0;
      repeat (3) @(negedge clk);
      check("reset_outputs", {in_ready, sym_i, sym_q, sym_strobe, tx_en, busy}, 6'b100000);
      #2 rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("idle_after_release", {busy, tx_en}, 2'b00);

      // Single byte 0xB4
      clear_log();
      send(8'hB4);
      wait_idle();
      exp_q = '{2'b11, 2'b11, 2'b10, 2'b11, 2'b01, 2'b00, 2'b00};
      chk_log("b4_symbols");
      check("b4_busy_cycles", bcnt, 28);
      for (int k = 1; k < stb_cyc.size(); k++)
         check("b4_strobe_spacing", stb_cyc[k] - stb_cyc[k-1], 4);

      // Back-to-back 0xFF, 0x00
      clear_log();
      send(8'hFF);
      send(8'h00);
      wait_idle();
      exp_q = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
      chk_log("ff00_symbols");
      check("ff00_busy_cycles", bcnt, 44);

      // Extra byte offered while the hold is full is ignored
      clear_log();
      send(8'h5A);
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'h33;
      @(negedge clk);
      in_data  = 8'hC7;
      @(negedge clk);
      in_valid = 1'b0;
      wait_idle();
      exp_q = '{2'b11, 2'b11, 2'b01, 2'b01, 2'b10, 2'b10, 2'b00};
      chk_log("hold_full_ignore");

      // Byte arriving during the tail starts a fresh frame
      clear_log();
      send(8'h0F);
      wait_log(7);
      send(8'hF0);
      wait_log(14);
      wait_idle();
      exp_q = '{2'b11, 2'b11, 2'b00, 2'b00, 2'b11, 2'b11, 2'b00,
                2'b11, 2'b11, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00};
      chk_log("tail_then_new_frame");

      // Reset during the second data dibit
      clear_log();
      send(8'hC3);
      wait_log(4);
      #2 rst_n = 1'b0;
      #1 check("midframe_reset_outputs", {in_ready, sym_i, sym_q, sym_strobe, tx_en, busy}, 6'b100000);
      @(negedge clk);
      #2 rst_n = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("stay_idle_after_reset", {busy, in_ready}, 2'b01);
      end
      clear_log();
      send(8'h1B);
      wait_idle();
      exp_q = '{2'b11, 2'b11, 2'b00, 2'b01, 2'b10, 2'b11, 2'b00};
      chk_log("after_reset_1b");

      // Randomized traffic, with one asynchronous reset in the middle
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         in_valid = ($urandom_range(0, 3) == 0);
         in_data  = 8'($urandom);
         if (c == 1500) begin
            #2 rst_n = 1'b0;
            #4 rst_n = 1'b1;
         end
      end
      @(negedge clk);
      in_valid = 1'b0;
      wait_idle();
      repeat (4) @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/qpsk_tx_ctrl.md
QPSK_TX_CTRL -- requirements
Module: qpsk_tx_ctrl

Interface
REQ-001 The block SHALL have parameter SYM_DIV, default 800, giving clk cycles per QPSK symbol (2 bits).
REQ-002 The block SHALL have parameter PRE_SYMS, default 8, giving preamble length in symbols.
REQ-003 The block SHALL have parameter TAIL_SYMS, default 2, giving tail length in symbols.
REQ-004 The block SHALL have port clk, input, 1, the single system clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1, an asynchronous active-low reset.
REQ-006 The block SHALL have port in_data, input, 8, the payload byte from the requester.
REQ-007 The block SHALL have port in_valid, input, 1, which marks in_data as valid.
REQ-008 The block SHALL have port in_ready, output, 1, which is high when the holding register is empty.
REQ-009 The block SHALL have port sym_i, output, 1, the in-phase bit to the modulator.
REQ-010 The block SHALL have port sym_q, output, 1, the quadrature bit to the modulator.
REQ-011 The block SHALL have port sym_strobe, output, 1, a one-cycle pulse at the first cycle of every symbol.
REQ-012 The block SHALL have port tx_en, output, 1, the modulator carrier enable, high in PREAMBLE, DATA and TAIL.
REQ-013 The block SHALL have port busy, output, 1, which is high whenever the state is not IDLE.

Function
REQ-014 The block SHALL transfer a byte into the one-byte holding register on a clk edge where in_valid and in_ready are both high; in_ready SHALL equal the inverse of the hold-full flag, with no combinational path from in_valid.
REQ-015 The FSM SHALL have exactly four states: IDLE, PREAMBLE, DATA and TAIL.
REQ-016 IDLE -> PREAMBLE SHALL occur on the first cycle where the hold is full, and the first preamble symbol starts on the next cycle.
REQ-017 PREAMBLE SHALL emit PRE_SYMS symbols of (I,Q)=(1,1), then go to DATA, loading the hold into the shift register and clearing the hold-full flag at that symbol boundary.
REQ-018 DATA SHALL emit 4 dibits per byte, MSB first: (bit7,bit6), (bit5,bit4), (bit3,bit2), (bit1,bit0).
REQ-019 At the end of the 4th dibit with the hold full, the block SHALL reload the shift register from the hold and continue DATA with no gap symbol.
REQ-020 At the end of the 4th dibit with the hold empty, the block SHALL go to TAIL.
REQ-021 TAIL SHALL emit TAIL_SYMS symbols of (0,0), then go to IDLE.
REQ-022 A byte accepted during TAIL SHALL NOT be appended to the ending frame; after the return to IDLE it SHALL start a new frame with a fresh preamble.
REQ-023 Symbol timing: a divider counter SHALL count 0..SYM_DIV-1 while busy and wrap to 0.
REQ-024 sym_strobe SHALL be high exactly when the divider count is 0 while busy.
REQ-025 sym_i and sym_q SHALL update only in the strobe cycle and hold for SYM_DIV cycles.
REQ-026 The divider counter width SHALL be clog2(SYM_DIV); a separate symbol counter SHALL be sized for max(PRE_SYMS,TAIL_SYMS); the dibit index SHALL be 2 bits and wrap 3->0.
REQ-027 In IDLE: sym_i=0, sym_q=0, tx_en=0, busy=0, sym_strobe=0, and the divider counter is held at 0.
REQ-028 A byte arriving exactly at a symbol boundary where the hold is being loaded into the shift register SHALL NOT be accepted in that cycle (in_ready is low) and SHALL be accepted on the following cycle.
REQ-029 in_valid held high continuously SHALL produce back-to-back bytes with no tail between them.

Reset
REQ-030 On rst_n low, the block SHALL asynchronously set: state=IDLE, hold-full=0, all counters=0, shift register=0.
REQ-031 On rst_n low, the outputs SHALL be: in_ready=1, sym_i=0, sym_q=0, sym_strobe=0, tx_en=0, busy=0.
REQ-032 Reset asserted mid-frame SHALL abort the frame immediately and discard any held byte; after release the block SHALL remain in IDLE until a new byte is accepted.
REQ-033 Reset release SHALL take effect synchronously to clk.

Verification (SYM_DIV=4, PRE_SYMS=2, TAIL_SYMS=1)
REQ-034 Single byte 0xB4 -> 2 symbols (1,1), then (1,0),(1,1),(0,1),(0,0), then 1 symbol (0,0); 7 strobes spaced 4 cycles apart; busy high for 28 cycles; tx_en deasserts at the same time as busy.
REQ-035 Bytes 0xFF then 0x00 with in_valid held high -> preamble, 4x(1,1), 4x(0,0), tail; no gap symbol; in_ready low while the hold is full.
REQ-036 in_valid pulsed while hold full -> byte not accepted; in_data changes ignored; the earlier byte is transmitted intact.
REQ-037 rst_n pulsed low during the 2nd data dibit -> all outputs go to their reset values within the same cycle; a new byte 0x1B then yields a full preamble followed by (0,0),(0,1),(1,0),(1,1).
REQ-038 Byte accepted during TAIL -> TAIL completes, one IDLE cycle follows, then a new PREAMBLE starts.
